// File: rtl/cluster_config_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cluster_config_loader: byte-fed serialiser driving a cluster config chain |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module cluster_config_loader #(
  parameter int CHAIN_LEN = 350,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       prog_clk,
  output logic       prog_en,
  output logic       prog_in,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int PH_W  = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] C_CHAIN = CNT_W'(CHAIN_LEN);
  localparam logic [PH_W-1:0]  C_DIV   = PH_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] C_LAST  = CNT_W'(1);
  localparam logic [PH_W-1:0]  C_PH1   = PH_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOW    = 3'd2,
    HIGH   = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t           state_q,    state_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic [PH_W-1:0]  phase_q,    phase_d;
  logic [2:0]       bit_idx_q,  bit_idx_d;
  logic [7:0]       act_byte_q, act_byte_d;
  logic [7:0]       pf_byte_q,  pf_byte_d;
  logic             pf_vld_q,   pf_vld_d;
  logic             prog_clk_q, prog_clk_d;
  logic             prog_en_q,  prog_en_d;
  logic             prog_in_q,  prog_in_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic [2:0]       next_idx;
  logic             accept;

  assign in_ready = busy_q && !pf_vld_q;
  assign accept   = in_valid && in_ready;
  assign next_idx = bit_idx_q + 3'd1;

  assign prog_clk = prog_clk_q;
  assign prog_en  = prog_en_q;
  assign prog_in  = prog_in_q;
  assign busy     = busy_q;
  assign done     = done_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    act_byte_d = act_byte_q;
    pf_byte_d  = pf_byte_q;
    pf_vld_d   = pf_vld_q;
    prog_clk_d = prog_clk_q;
    prog_en_d  = prog_en_q;
    prog_in_d  = prog_in_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Accepts only land in an empty prefetch slot; the moves below only fire
    // when it is full, so the two never collide and FINISH can flush freely.
    if (accept) begin
      pf_byte_d = in_data;
      pf_vld_d  = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          busy_d    = 1'b1;
          bit_cnt_d = C_CHAIN;
          pf_vld_d  = 1'b0;
        end
      end
      FETCH: begin
        if (pf_vld_q) begin
          act_byte_d = pf_byte_q;
          pf_vld_d   = 1'b0;
          bit_idx_d  = 3'd0;
          prog_in_d  = pf_byte_q[0];
          prog_en_d  = 1'b1;
          phase_d    = C_PH1;
          state_d    = LOW;
        end
      end
      LOW: begin
        if (phase_q == C_DIV) begin
          phase_d    = C_PH1;
          prog_clk_d = 1'b1;
          state_d    = HIGH;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      HIGH: begin
        if (phase_q == C_DIV) begin
          phase_d    = C_PH1;
          prog_clk_d = 1'b0;
          bit_cnt_d  = bit_cnt_q - 1'b1;
          bit_idx_d  = next_idx;
          if (bit_cnt_q == C_LAST) begin
            prog_en_d = 1'b0;
            prog_in_d = 1'b0;
            done_d    = 1'b1;
            state_d   = FINISH;
          end else if (bit_idx_q == 3'd7) begin
            // Byte exhausted: a full prefetch slot is swapped in without a FETCH bubble.
            if (pf_vld_q) begin
              act_byte_d = pf_byte_q;
              pf_vld_d   = 1'b0;
              prog_in_d  = pf_byte_q[0];
              state_d    = LOW;
            end else begin
              state_d = FETCH;
            end
          end else begin
            prog_in_d = act_byte_q[next_idx];
            state_d   = LOW;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      FINISH: begin
        busy_d   = 1'b0;
        pf_vld_d = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      phase_q    <= '0;
      bit_idx_q  <= '0;
      act_byte_q <= '0;
      pf_byte_q  <= '0;
      pf_vld_q   <= 1'b0;
      prog_clk_q <= 1'b0;
      prog_en_q  <= 1'b0;
      prog_in_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      act_byte_q <= act_byte_d;
      pf_byte_q  <= pf_byte_d;
      pf_vld_q   <= pf_vld_d;
      prog_clk_q <= prog_clk_d;
      prog_en_q  <= prog_en_d;
      prog_in_q  <= prog_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule
`default_nettype wire
